// File: rtl/imm_ext_pkg.sv
// imm_ext_pkg
//   Shared types for the immediate-extension pipeline stage.
//   - ext_mode_e   : 2-bit extension mode carried on in_mode
//   - pipe_state_e : handshake state of imm_extend_pipe. The encoding is
//                    {skid_valid, out_valid}, so each valid bit can be read
//                    straight out of the state register.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO   = 2'b00,
        EXT_SIGN   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } ext_mode_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,  // nothing held
        ST_FULL  = 2'b01,  // output register holds a beat
        ST_SKID  = 2'b11   // output and skid registers both hold a beat
    } pipe_state_e;

    localparam int ST_OUT_VALID_BIT  = 0;
    localparam int ST_SKID_VALID_BIT = 1;

endpackage

// File: rtl/imm_ext_core.sv
// imm_ext_core
//   Purely combinational immediate extender.
//   Ports:
//     imm  [IN_W-1:0]  raw immediate
//     mode [1:0]       extension mode (ext_mode_e)
//     ext  [OUT_W-1:0] extended operand
//   Modes: ZERO pads with zeros, SIGN replicates imm MSB, UPPER places imm in
//   the top IN_W bits, BRANCH is the SIGN result shifted left by two.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    localparam int PAD_W = OUT_W - IN_W;

    logic             sgn;
    logic [OUT_W-1:0] sign_ext;

    assign sgn      = imm[IN_W-1];
    assign sign_ext = {{PAD_W{sgn}}, imm};

    always_comb begin
        ext = '0;
        case (ext_mode_e'(mode))
            EXT_ZERO:   ext = {{PAD_W{1'b0}}, imm};
            EXT_SIGN:   ext = sign_ext;
            EXT_UPPER:  ext = {imm, {PAD_W{1'b0}}};
            // The two MSBs of the sign-extended value fall off the top.
            EXT_BRANCH: ext = {sign_ext[OUT_W-3:0], 2'b00};
            default:    ext = '0;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
//   Pipelined immediate-extension stage for the ID/EX boundary. The immediate
//   is extended as it is accepted; an output register plus a one-entry skid
//   register hold already-extended data and its tag.
//   Ports:
//     clk, rst_n         clock, asynchronous active-low reset
//     flush              synchronous flush: drops every held beat
//     in_valid/in_ready  input handshake (in_ready is a flop)
//     in_imm/in_mode     immediate and extension mode
//     in_tag             sideband tag, passed through unmodified
//     out_valid/out_ready output handshake
//     out_data/out_tag   extended operand and its tag (registered)
//
//   Handshake: a beat transfers on a rising edge where valid and ready are
//   both 1. The sender must hold a beat and its payload stable until that
//   edge; this block keeps out_data/out_tag stable while out_valid=1 and
//   out_ready=0, and in_ready never depends on out_ready in the same cycle.
//
//   state_q is the handshake FSM state ({skid_valid, out_valid}); it is the
//   single point to observe EMPTY/FULL/SKID.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);

    // BRANCH mode needs two bits of headroom above the immediate.
    generate
        if (OUT_W < IN_W + 2) begin : g_bad_width
            $error("imm_extend_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    pipe_state_e      state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic [OUT_W-1:0] skid_data_q, skid_data_d;
    logic [TAG_W-1:0] skid_tag_q, skid_tag_d;

    logic [OUT_W-1:0] ext_data;
    logic             in_fire;
    logic             out_fire;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm  (in_imm),
        .mode (in_mode),
        .ext  (ext_data)
    );

    assign out_valid = state_q[ST_OUT_VALID_BIT];
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        skid_data_d = skid_data_q;
        skid_tag_d  = skid_tag_q;

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    out_data_d = ext_data;
                    out_tag_d  = in_tag;
                    state_d    = ST_FULL;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    out_data_d = ext_data;
                    out_tag_d  = in_tag;
                end else if (in_fire) begin
                    // Output is stalled: park the new beat in the skid.
                    skid_data_d = ext_data;
                    skid_tag_d  = in_tag;
                    state_d     = ST_SKID;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                // in_ready is low here, so only the output side can move.
                if (out_fire) begin
                    out_data_d = skid_data_q;
                    out_tag_d  = skid_tag_q;
                    state_d    = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        // Flush only drops the valid bits; data registers keep whatever
        // they were about to hold.
        if (flush) begin
            state_d = ST_EMPTY;
        end

        // in_ready is registered: computed from the next state so it never
        // sees this cycle's out_ready combinationally.
        in_ready_d = (state_d != ST_SKID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            skid_data_q <= '0;
            skid_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            skid_data_q <= skid_data_d;
            skid_tag_q  <= skid_tag_d;
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
//   Self-checking bench for imm_extend_pipe: a 16/32 instance exercised with
//   directed and random traffic, plus 12/32 and 16/64 instances fed random
//   immediates. Expected values come from ext_model(), which evaluates the
//   extension rules with integer arithmetic, and from a capacity-2 queue
//   model of the buffering.
module tb_imm_extend_pipe;

    localparam int TAG_W = 5;
    localparam int W     = TAG_W + 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- main DUT (16 -> 32) ----------------
    logic             flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0]      in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [31:0]      out_data;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag)
    );

    // ---------------- sweep DUTs ----------------
    logic             s_flush = 1'b0;
    logic             s_out_ready = 1'b1;
    logic             s_in_valid;
    logic [1:0]       s12_mode, s64_mode;
    logic [11:0]      s12_imm;
    logic [15:0]      s64_imm;
    logic [TAG_W-1:0] s_tag;
    logic             s12_in_ready, s12_out_valid, s64_in_ready, s64_out_valid;
    logic [31:0]      s12_out_data;
    logic [63:0]      s64_out_data;
    logic [TAG_W-1:0] s12_out_tag, s64_out_tag;

    imm_extend_pipe #(.IN_W(12), .OUT_W(32), .TAG_W(TAG_W)) dut12 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s12_in_ready),
        .in_imm(s12_imm), .in_mode(s12_mode), .in_tag(s_tag),
        .out_valid(s12_out_valid), .out_ready(s_out_ready),
        .out_data(s12_out_data), .out_tag(s12_out_tag)
    );

    imm_extend_pipe #(.IN_W(16), .OUT_W(64), .TAG_W(TAG_W)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s64_in_ready),
        .in_imm(s64_imm), .in_mode(s64_mode), .in_tag(s_tag),
        .out_valid(s64_out_valid), .out_ready(s_out_ready),
        .out_data(s64_out_data), .out_tag(s64_out_tag)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] ext_model(input logic [63:0] imm, input logic [1:0] mode,
                                              input int in_w, input int out_w);
        longint      sv;
        logic [63:0] mask;
        logic [63:0] r;
        mask = (out_w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << out_w) - 64'd1);
        // Signed value of the immediate as an ordinary integer.
        if (imm[in_w-1]) sv = longint'(imm) - (longint'(1) << in_w);
        else             sv = longint'(imm);
        case (mode)
            2'd0:    r = imm;
            2'd1:    r = 64'(sv);
            2'd2:    r = imm * (64'd1 << (out_w - in_w));
            default: r = 64'(sv * 4);
        endcase
        return r & mask;
    endfunction

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic [63:0]  exp12_q[$];
    logic [63:0]  exp64_q[$];
    logic [W-1:0] e;
    logic [W-1:0] hold_val;
    logic         stall_prev = 1'b0;
    logic [63:0]  e64;
    int           n_delivered = 0;

    // Samples on the falling edge: current outputs are compared against the
    // model, then the events of the coming rising edge are applied to it.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp12_q.delete();
            exp64_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("m_out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("m_in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
            if (stall_prev && out_valid)
                check("m_hold", 64'({out_tag, out_data}), 64'(hold_val));
            stall_prev = out_valid && !out_ready;
            hold_val   = {out_tag, out_data};
            if (out_valid && out_ready && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("m_data", 64'(out_data), 64'(e[31:0]));
                check("m_tag", 64'(out_tag), 64'(e[W-1:32]));
                n_delivered++;
            end
            if (flush) exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back({in_tag, ext_model({48'd0, in_imm}, in_mode, 16, 32)[31:0]});

            check("s12_out_valid", 64'(s12_out_valid), 64'(exp12_q.size() > 0));
            check("s64_out_valid", 64'(s64_out_valid), 64'(exp64_q.size() > 0));
            if (s12_out_valid && exp12_q.size() > 0) begin
                e64 = exp12_q.pop_front();
                check("s12_data", 64'(s12_out_data), e64);
            end
            if (s64_out_valid && exp64_q.size() > 0) begin
                e64 = exp64_q.pop_front();
                check("s64_data", s64_out_data, e64);
            end
            if (s_in_valid && s12_in_ready)
                exp12_q.push_back(ext_model({52'd0, s12_imm}, s12_mode, 12, 32));
            if (s_in_valid && s64_in_ready)
                exp64_q.push_back(ext_model({48'd0, s64_imm}, s64_mode, 16, 64));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        int   waits;
        logic ok;
        in_valid = 1'b1;
        in_imm   = imm;
        in_mode  = mode;
        in_tag   = tag;
        waits    = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waits++;
            if (waits > 50) begin
                check("send_timeout", 64'(waits), 64'd0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] mode_gold[4];
    int          d0;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_imm = '0; in_mode = '0; in_tag = '0;
        s_in_valid = 1'b0; s12_imm = '0; s64_imm = '0;
        s12_mode = '0; s64_mode = '0; s_tag = '0;
        mode_gold[0] = 32'h0000_8004;
        mode_gold[1] = 32'hFFFF_8004;
        mode_gold[2] = 32'h8004_0000;
        mode_gold[3] = 32'hFFFE_0010;

        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed mode vectors.
        for (int m = 0; m < 4; m++) begin
            send(16'h8004, 2'(m), 5'(m));
            @(negedge clk);
            check("mode_vec", 64'(out_data), 64'(mode_gold[m]));
            @(posedge clk); #1;
        end
        send(16'h7FFF, 2'd1, 5'd9);
        @(negedge clk);
        check("sign_pos", 64'(out_data), 64'h0000_7FFF);
        @(posedge clk); #1;
        idle(2);

        // Backpressure: tags 1..6, output stalled after the first beat.
        out_ready = 1'b0;
        d0 = n_delivered;
        send(16'h0111, 2'd1, 5'd1);
        send(16'h0222, 2'd1, 5'd2);
        @(negedge clk);
        check("bp_in_ready", 64'(in_ready), 64'd0);
        check("bp_hold_tag", 64'(out_tag), 64'd1);
        check("bp_hold_data", 64'(out_data), 64'h0000_0111);
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int t = 3; t <= 6; t++) send(16'(t * 16'h0111), 2'd1, 5'(t));
        idle(3);
        check("bp_count", 64'(n_delivered - d0), 64'd6);

        // Full-rate random stream.
        d0 = n_delivered;
        for (int i = 0; i < 100; i++)
            send(16'($urandom), 2'($urandom_range(0, 3)), 5'($urandom));
        idle(2);
        check("fr_count", 64'(n_delivered - d0), 64'd100);

        // Flush while in SKID with a beat presented.
        out_ready = 1'b0;
        send(16'h1234, 2'd0, 5'd10);
        send(16'h5678, 2'd0, 5'd11);
        in_valid = 1'b1; in_imm = 16'h9ABC; in_tag = 5'd12; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        idle(3);
        send(16'h0042, 2'd2, 5'd13);
        @(negedge clk);
        check("fl_next_valid", 64'(out_valid), 64'd1);
        check("fl_next_tag", 64'(out_tag), 64'd13);
        @(posedge clk); #1;

        // Random traffic with random stalls, then async reset mid-stream.
        for (int i = 0; i < 12; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        in_valid  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready", 64'(in_ready), 64'd1);
        check("arst_out_data", 64'(out_data), 64'd0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_valid  = 1'($urandom);
            out_ready = 1'($urandom);
            in_imm    = 16'($urandom);
            in_mode   = 2'($urandom);
            in_tag    = 5'($urandom);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(4);

        // Parameter sweep instances.
        for (int i = 0; i < 80; i++) begin
            s_in_valid = 1'b1;
            s12_imm    = 12'($urandom);
            s64_imm    = 16'($urandom);
            s12_mode   = 2'($urandom);
            s64_mode   = 2'($urandom);
            s_tag      = 5'($urandom);
            @(posedge clk); #1;
        end
        s_in_valid = 1'b0;
        idle(3);

        check("drain_main", 64'(exp_q.size()), 64'd0);
        check("drain_s12", 64'(exp12_q.size()), 64'd0);
        check("drain_s64", 64'(exp64_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension stage for the instruction-decode path. Takes an IN_W-bit immediate plus a 2-bit extension mode and produces an OUT_W-bit operand for the ID/EX boundary. Modes cover zero, sign, upper (load-upper) and branch-offset extension. Input and output use valid/ready handshakes through a one-entry skid buffer, so the block absorbs downstream stalls at full throughput and supports a pipeline flush.

## Interface
- IN_W, 16, immediate field width
- OUT_W, 32, extended operand width; OUT_W >= IN_W+2 required (elaboration-time check)
- TAG_W, 5, sideband tag width (e.g. destination register), passed through unmodified
- clk  input  1  rising-edge clock; one clock domain
- rst_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous pipeline flush
- in_valid  input  1  input beat valid
- in_ready  output  1  block can accept a beat (registered)
- in_imm  input  IN_W  raw immediate
- in_mode  input  2  extension mode
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts beat
- out_data  output  OUT_W  extended operand
- out_tag  output  TAG_W  tag accompanying out_data

## Operation
- Modes, with s = in_imm[IN_W-1]:
  - 00 ZERO: upper OUT_W-IN_W bits 0, low bits in_imm
  - 01 SIGN: upper bits all s (replicated, not the constant 1), low bits in_imm
  - 10 UPPER: in_imm placed at [OUT_W-1 : OUT_W-IN_W], all lower bits 0
  - 11 BRANCH: SIGN result shifted left 2, bits shifted out of the MSB discarded, bits [1:0] = 0
- Extension is computed on accept; the skid and output registers hold already-extended data plus tag.
- Input fire = in_valid & in_ready. Output fire = out_valid & out_ready.
- States, derived from out_valid and skid_valid:
  - EMPTY: out_valid=0, in_ready=1. Input fire -> FULL.
  - FULL: out_valid=1, in_ready=1. In fire & out fire -> FULL (new data to output). In fire & no out fire -> SKID (beat captured in skid). Out fire & no in fire -> EMPTY.
  - SKID: out_valid=1, in_ready=0. Out fire -> FULL (skid moves to output). Otherwise stay.
- out_data/out_tag stay stable while out_valid=1 and out_ready=0.
- Flush has priority over every other event: at the next edge both valid bits clear, state becomes EMPTY, and in_ready=1. A beat presented in the flush cycle is dropped. An output beat accepted in the flush cycle counts as delivered.
- Data registers are not cleared by flush; only the valid bits are.

## Timing
- Reset values: out_valid=0, in_ready=1, out_data=0, out_tag=0, skid_valid=0, skid contents 0.
- Latency: 1 cycle from input fire to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready depends only on registered state, with no combinational path from out_ready. out_valid/out_data are registered outputs.
- Reset asserted mid-transfer: all state returns to reset values immediately, with no edge needed. The first accept is allowed on the first edge after rst_n deasserts.
- In-order delivery is guaranteed; no beat is duplicated or lost except under flush.

## Structure
- Package imm_ext_pkg:
  - mode enum: EXT_ZERO=2'b00, EXT_SIGN=2'b01, EXT_UPPER=2'b10, EXT_BRANCH=2'b11
  - state encoding constants
- Sub-module imm_ext_core (combinational, parametrised IN_W/OUT_W) implements the four modes. It is instantiated once on the input side.
- Top level holds the skid register, output register and handshake control.

## Test plan
- Modes, IN_W=16/OUT_W=32, out_ready=1, in_imm=16'h8004:
  - ZERO -> 32'h0000_8004
  - SIGN -> 32'hFFFF_8004
  - UPPER -> 32'h8004_0000
  - BRANCH -> 32'hFFFE_0010
  - in_imm=16'h7FFF, SIGN -> 32'h0000_7FFF
- Backpressure: stream tags 1..6 with out_ready held 0 after the first beat. Required: in_ready drops after the second accept, and out_data holds beat 1. Release out_ready: tags 1..6 emerge in order, one per cycle, none lost.
- Full-rate stream of 100 random beats with out_ready=1 -> 100 outputs, each exactly one cycle after its input, in_ready constantly 1.
- Flush in SKID state with in_valid=1 -> next cycle out_valid=0, in_ready=1. No flushed beat appears later. The next beat has latency 1.
- Assert rst_n=0 asynchronously mid-stream (between edges) -> out_valid=0 and in_ready=1 immediately, out_data=0. After release, normal operation resumes.
- Parameter sweep IN_W=12/OUT_W=32, and IN_W=16/OUT_W=64 -> golden-model match for all modes over random immediates.
